// File: rtl/mitchell_antilog_pipe_if.sv
// Valid/ready stream bundle for the Mitchell antilog converter.
// master = producer/consumer side, slave = converter side.
interface mitchell_antilog_pipe_if #(
  parameter int unsigned LOG_W = 16,
  parameter int unsigned OUT_W = 16
);
  logic             in_valid;
  logic             in_ready;
  logic [LOG_W-1:0] log_in;
  logic             sign_in;
  logic             zero_in;
  logic             out_valid;
  logic             out_ready;
  logic [OUT_W-1:0] lin_out;
  logic             sat_out;

  modport master (
    output in_valid, log_in, sign_in, zero_in, out_ready,
    input  in_ready, out_valid, lin_out, sat_out
  );

  modport slave (
    input  in_valid, log_in, sign_in, zero_in, out_ready,
    output in_ready, out_valid, lin_out, sat_out
  );
endinterface

// File: rtl/mitchell_antilog_pipe.sv
// Mitchell antilog: 2^(k+f) ~= 2^k * (1+f), log-domain operand to signed linear fixed point.
// Three-stage valid/ready pipeline (decompose, shift/saturate, sign) with a saturation counter.
module mitchell_antilog_pipe #(
  parameter int unsigned LOG_W    = 16,
  parameter int unsigned OUT_W    = 16,
  parameter int unsigned OUT_FRAC = 12,
  parameter int unsigned CNT_W    = 16
) (
  input  logic                   clk,
  input  logic                   rst_n,
  mitchell_antilog_pipe_if.slave bus,
  input  logic                   clr_cnt,
  output logic [CNT_W-1:0]       sat_cnt
);
  localparam int unsigned FW = LOG_W - 4;
  localparam int unsigned MW = FW + 1;
  // Wide enough for the largest left shift of the mantissa plus the saturation compare.
  localparam int unsigned WW = MW + OUT_FRAC + OUT_W + 8;

  // Stage 1: decomposed operand
  logic                   s1_valid_q;
  logic signed [3:0]      s1_k_q;
  logic [MW-1:0]          s1_m_q;
  logic                   s1_sign_q;
  logic                   s1_zero_q;

  // Stage 2: unsigned magnitude
  logic                   s2_valid_q;
  logic [OUT_W-2:0]       s2_mag_q;
  logic                   s2_sat_q;
  logic                   s2_sign_q;

  // Stage 3: signed result
  logic                   s3_valid_q;
  logic [OUT_W-1:0]       s3_lin_q;
  logic                   s3_sat_q;

  logic [CNT_W-1:0]       cnt_q;

  logic                   s1_ready;
  logic                   s2_ready;
  logic                   s3_ready;
  logic                   out_fire;

  int                     sh;
  logic [WW-1:0]          m_ext;
  logic [WW-1:0]          shifted;
  logic                   sat_d;
  logic [OUT_W-2:0]       mag_d;
  logic [OUT_W-1:0]       lin_d;

  // Ready ripples back from out_ready so a full pipe still streams at one per cycle.
  always_comb begin
    s3_ready = ~s3_valid_q | bus.out_ready;
    s2_ready = ~s2_valid_q | s3_ready;
    s1_ready = ~s1_valid_q | s2_ready;
    out_fire = s3_valid_q & bus.out_ready;
  end

  assign bus.in_ready  = s1_ready;
  assign bus.out_valid = s3_valid_q;
  assign bus.lin_out   = s3_lin_q;
  assign bus.sat_out   = s3_sat_q;
  assign sat_cnt       = cnt_q;

  // Mantissa carries FW fractional bits; the output wants OUT_FRAC, so fold the difference in.
  always_comb begin
    sh    = int'(s1_k_q) + int'(OUT_FRAC) - int'(FW);
    m_ext = {{(WW-MW){1'b0}}, s1_m_q};
    if (sh >= 0) begin
      shifted = m_ext << sh;
    end else begin
      shifted = m_ext >> (-sh);
    end
    sat_d = ~s1_zero_q & (|shifted[WW-1:OUT_W-1]);
    if (s1_zero_q) begin
      mag_d = '0;
    end else if (sat_d) begin
      mag_d = '1;
    end else begin
      mag_d = shifted[OUT_W-2:0];
    end
  end

  // Symmetric range: negating a clamped magnitude never reaches the most negative code.
  always_comb begin
    if (s2_sign_q) begin
      lin_d = -{1'b0, s2_mag_q};
    end else begin
      lin_d = {1'b0, s2_mag_q};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid_q <= 1'b0;
      s1_k_q     <= '0;
      s1_m_q     <= '0;
      s1_sign_q  <= 1'b0;
      s1_zero_q  <= 1'b0;
      s2_valid_q <= 1'b0;
      s2_mag_q   <= '0;
      s2_sat_q   <= 1'b0;
      s2_sign_q  <= 1'b0;
      s3_valid_q <= 1'b0;
      s3_lin_q   <= '0;
      s3_sat_q   <= 1'b0;
    end else begin
      if (s1_ready) begin
        s1_valid_q <= bus.in_valid;
        if (bus.in_valid) begin
          s1_k_q    <= bus.log_in[LOG_W-1 -: 4];
          s1_m_q    <= {1'b1, bus.log_in[FW-1:0]};
          s1_sign_q <= bus.sign_in;
          s1_zero_q <= bus.zero_in;
        end
      end
      if (s2_ready) begin
        s2_valid_q <= s1_valid_q;
        if (s1_valid_q) begin
          s2_mag_q  <= mag_d;
          s2_sat_q  <= sat_d;
          s2_sign_q <= s1_sign_q;
        end
      end
      if (s3_ready) begin
        s3_valid_q <= s2_valid_q;
        if (s2_valid_q) begin
          s3_lin_q <= lin_d;
          s3_sat_q <= s2_sat_q;
        end
      end
    end
  end

  // Clear wins over a coincident increment; the count sticks at all-ones.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else if (clr_cnt) begin
      cnt_q <= '0;
    end else if (out_fire && s3_sat_q && !(&cnt_q)) begin
      cnt_q <= cnt_q + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_mitchell_antilog_pipe.sv
// Scoreboard bench for mitchell_antilog_pipe: directed table cases, backpressure,
// randomized stream against an arithmetic reference model, and mid-stream reset.
module tb_mitchell_antilog_pipe;
  typedef struct {
    logic [15:0] lin;
    logic        sat;
    int          cyc;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        clr_cnt = 1'b0;
  logic [15:0] sat_cnt;

  mitchell_antilog_pipe_if #(.LOG_W(16), .OUT_W(16)) bus ();

  mitchell_antilog_pipe #(
    .LOG_W(16), .OUT_W(16), .OUT_FRAC(12), .CNT_W(16)
  ) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus), .clr_cnt(clr_cnt), .sat_cnt(sat_cnt)
  );

  always #5 clk = ~clk;

  exp_t        sb[$];
  int          checks = 0;
  int          errors = 0;
  int          cyc = 0;
  bit          chk_lat = 1'b0;
  int          exp_cnt = 0;
  int          n_in = 0;
  int          n_out = 0;
  bit          rand_on = 1'b0;
  exp_t        mon_e;
  logic [15:0] held_lin;
  logic        held_sat;
  bit          hold_v = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, req);
    end
  endtask

  task automatic fail_now(input string name);
    checks++;
    errors++;
    $display("FAIL %s actual=timeout required=event", name);
  endtask

  // Reference: linear = (1 + f/4096) * 2^k, scaled by 4096, truncated, clamped, signed.
  function automatic void model(input logic [15:0] lg, input logic s, input logic z,
                                output logic [15:0] lin, output logic sat);
    int     k;
    longint mant;
    longint mag;
    k = int'(lg[15:12]);
    if (k > 7) k -= 16;
    mant = 64'd4096 + longint'(lg[11:0]);
    if (k >= 0) mag = mant * (2 ** k);
    else mag = mant / (2 ** (-k));
    sat = (mag > 32767);
    if (sat) mag = 32767;
    if (z) begin
      mag = 0;
      sat = 1'b0;
    end
    lin = s ? 16'(-mag) : 16'(mag);
  endfunction

  // Monitor: pops on every output transfer, and checks outputs hold while stalled.
  always @(negedge clk) begin
    if (!rst_n) begin
      hold_v = 1'b0;
    end else if (bus.out_valid) begin
      if (hold_v) begin
        check("stall_lin", bus.lin_out, held_lin);
        check("stall_sat", bus.sat_out, held_sat);
      end
      if (bus.out_ready) begin
        hold_v = 1'b0;
        if (sb.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_output actual=%h required=none", bus.lin_out);
        end else begin
          mon_e = sb.pop_front();
          check("lin_out", bus.lin_out, mon_e.lin);
          check("sat_out", bus.sat_out, mon_e.sat);
          if (chk_lat) check("latency", cyc - mon_e.cyc, 3);
          if (mon_e.sat && exp_cnt != 65535) exp_cnt++;
          n_out++;
        end
      end else begin
        hold_v   = 1'b1;
        held_lin = bus.lin_out;
        held_sat = bus.sat_out;
      end
    end else begin
      hold_v = 1'b0;
    end
  end

  task automatic send(input logic [15:0] lg, input logic s, input logic z,
                      input logic [15:0] elin, input logic esat);
    int   tries = 0;
    bit   done = 1'b0;
    exp_t e;
    bus.in_valid = 1'b1;
    bus.log_in   = lg;
    bus.sign_in  = s;
    bus.zero_in  = z;
    while (!done) begin
      @(negedge clk);
      if (bus.in_ready) begin
        e.lin = elin;
        e.sat = esat;
        e.cyc = cyc;
        sb.push_back(e);
        n_in++;
        done = 1'b1;
      end else if (++tries > 100) begin
        fail_now("in_ready_wait");
        done = 1'b1;
      end
      @(posedge clk);
      #1;
    end
    bus.in_valid = 1'b0;
    bus.log_in   = 16'($urandom);
    bus.sign_in  = 1'($urandom);
    bus.zero_in  = 1'($urandom);
  endtask

  task automatic sendm(input logic [15:0] lg, input logic s, input logic z);
    logic [15:0] l;
    logic        st;
    model(lg, s, z, l, st);
    send(lg, s, z, l, st);
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic drain();
    int t = 0;
    while (sb.size() != 0 && t < 300) begin
      @(posedge clk);
      #1;
      t++;
    end
    if (sb.size() != 0) fail_now("drain");
  endtask

  initial begin
    int t;
    bus.in_valid  = 1'b0;
    bus.log_in    = '0;
    bus.sign_in   = 1'b0;
    bus.zero_in   = 1'b0;
    bus.out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(negedge clk);
    check("rst_out_valid", bus.out_valid, 0);
    check("rst_lin_out", bus.lin_out, 0);
    check("rst_sat_out", bus.sat_out, 0);
    check("rst_sat_cnt", sat_cnt, 0);
    check("rst_in_ready", bus.in_ready, 1);
    @(posedge clk);
    #1;

    // Directed table cases with latency tracking.
    chk_lat = 1'b1;
    send(16'h0000, 1'b0, 1'b0, 16'h1000, 1'b0);
    send(16'hF000, 1'b0, 1'b0, 16'h0800, 1'b0);
    send(16'h0800, 1'b0, 1'b0, 16'h1800, 1'b0);
    send(16'h2800, 1'b0, 1'b0, 16'h6000, 1'b0);
    send(16'h8000, 1'b0, 1'b0, 16'h0010, 1'b0);
    idle(2);
    send(16'hA920, 1'b0, 1'b0, 16'h0064, 1'b0);
    send(16'hA920, 1'b1, 1'b0, 16'hFF9C, 1'b0);
    send(16'h3000, 1'b1, 1'b1, 16'h0000, 1'b0);
    send(16'h1234, 1'b0, 1'b1, 16'h0000, 1'b0);
    drain();

    // Saturation and counter.
    send(16'h3000, 1'b0, 1'b0, 16'h7FFF, 1'b1);
    send(16'h3000, 1'b1, 1'b0, 16'h8001, 1'b1);
    drain();
    check("sat_cnt_two", sat_cnt, 2);
    send(16'h3000, 1'b0, 1'b0, 16'h7FFF, 1'b1);
    t = 0;
    do begin
      @(negedge clk);
      t++;
    end while (!bus.out_valid && t < 20);
    if (!bus.out_valid) fail_now("sat3_output");
    clr_cnt = 1'b1;
    @(posedge clk);
    #1;
    clr_cnt = 1'b0;
    exp_cnt = 0;
    check("sat_cnt_clr_prio", sat_cnt, 0);
    chk_lat = 1'b0;

    // Backpressure: 8 back-to-back operands, out_ready low for 5 cycles.
    bus.out_ready = 1'b0;
    fork
      begin
        for (int i = 0; i < 8; i++) sendm(16'(16'h1000 + i * 16'h0310), 1'(i), 1'b0);
      end
      begin
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("in_ready_full", bus.in_ready, 0);
        repeat (2) @(posedge clk);
        #1;
        bus.out_ready = 1'b1;
      end
    join
    drain();
    check("bp_count", n_out, n_in);

    // Randomized stream with random backpressure.
    rand_on = 1'b1;
    fork
      begin
        for (int i = 0; i < 1000; i++) begin
          if ($urandom_range(0, 2) == 0) idle($urandom_range(1, 3));
          sendm(16'($urandom), 1'($urandom), $urandom_range(0, 15) == 0);
        end
        rand_on = 1'b0;
      end
      begin
        while (rand_on) begin
          @(posedge clk);
          #1;
          bus.out_ready = ($urandom_range(0, 3) != 0);
        end
      end
    join
    bus.out_ready = 1'b1;
    drain();
    check("rand_count", n_out, n_in);
    check("rand_sat_cnt", sat_cnt, exp_cnt);

    // Reset with three operands in flight.
    send(16'h2800, 1'b0, 1'b0, 16'h6000, 1'b0);
    send(16'h3000, 1'b0, 1'b0, 16'h7FFF, 1'b1);
    send(16'hA920, 1'b0, 1'b0, 16'h0064, 1'b0);
    #1;
    rst_n = 1'b0;
    #1;
    sb.delete();
    check("mid_rst_out_valid", bus.out_valid, 0);
    check("mid_rst_lin_out", bus.lin_out, 0);
    check("mid_rst_sat_out", bus.sat_out, 0);
    check("mid_rst_sat_cnt", sat_cnt, 0);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check("post_rst_quiet", bus.out_valid, 0);
    end
    @(posedge clk);
    #1;
    send(16'h0800, 1'b1, 1'b0, 16'hE800, 1'b0);
    drain();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #5000000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/mitchell_antilog_pipe.md
Name: mitchell_antilog_pipe

Overview:
- Mitchell antilog converter: maps a log-domain operand back to linear signed fixed point using 2^(k+f) ≈ 2^k·(1+f).
- Operand format: signed Q3.12 log2 magnitude plus separate sign and zero flags, the same format the log sin/cos tables produce.
- Sits at the output of the log-domain trigonometric expansion and multiply path (log sums), feeding linear values to the adaptive-filter accumulator.
- Three-stage valid/ready pipeline with bubble collapsing, saturation and a saturation event counter.

Parameters:
- LOG_W, 16, log input width; signed, LOG_W-4 fractional bits (Q3.12 at default).
- OUT_W, 16, linear output width; signed two's complement.
- OUT_FRAC, 12, fractional bits of the output.
- CNT_W, 16, saturation counter width.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  input operand valid.
- in_ready  out  1  block can accept an operand this cycle.
- log_in  in  LOG_W  log2 magnitude; k = log_in[LOG_W-1:LOG_W-4] (signed -8..7), f = log_in[LOG_W-5:0].
- sign_in  in  1  1 = linear result is negative.
- zero_in  in  1  1 = operand represents exact zero; log_in is ignored.
- out_valid  out  1  output valid.
- out_ready  in  1  downstream accepts.
- lin_out  out  OUT_W  linear result, Q(OUT_W-OUT_FRAC-1).OUT_FRAC.
- sat_out  out  1  this result was saturated.
- sat_cnt  out  CNT_W  count of saturated results accepted downstream.
- clr_cnt  in  1  synchronous clear of sat_cnt.

Behaviour:
- Reset: all stage valid bits 0; out_valid=0, lin_out=0, sat_out=0, sat_cnt=0. in_ready=1 on the first cycle after reset release.
- Handshake:
  - Transfer occurs when valid&ready are both high at a clock edge.
  - Each stage S1..S3 loads when it is empty or its contents move forward in the same cycle.
  - in_ready = ~S1.valid | S1 advancing (combinational from out_ready through the chain).
  - Bubbles collapse; no combinational path from in_valid to out_valid.
  - Latency 3 cycles with out_ready held high; throughput 1/cycle.
- Held output: out_valid, lin_out and sat_out stay stable while out_valid=1 & out_ready=0. No drops, no duplicates, order preserved.
- S1 (decompose): register k, mantissa m = {1'b1, f} (13 bits at default), sign, zero.
- S2 (shift):
  - mag = m<<k when k≥0; m>>(-k) when k<0, truncating.
  - Rationale: m already carries 12 fractional bits, matching OUT_FRAC=12. If OUT_FRAC≠LOG_W-4, shift additionally by the difference.
  - Saturate when mag > 2^(OUT_W-1)-1: mag becomes 2^(OUT_W-1)-1 and the sat flag is set.
  - zero=1 forces mag=0 and sat=0.
- S3 (sign): lin_out = sign ? -mag : mag.
  - Range is symmetric, so the most negative output is -(2^(OUT_W-1)-1).
  - sign with zero produces 0.
- sat_cnt:
  - Increments on an output transfer with sat_out=1.
  - Saturates at all-ones; no wrap.
  - clr_cnt has priority over a simultaneous increment; the result is 0.
- Reset mid-stream: in-flight operands are discarded and nothing is emitted afterwards.
- in_valid=0 is legal at any cycle. log_in is ignored when in_valid=0.

Test Plan:
- Single operands, out_ready=1, latency checked at 3 cycles:
  - log_in=0x0000, sign=0 → lin_out=0x1000.
  - log_in=0xF000 → 0x0800.
  - log_in=0x0800 → 0x1800.
  - log_in=0x2800 → 0x6000.
  - log_in=0x8000 → 0x0010.
- Table round-trip: log_in=0xA920 (k=-6, f=0x920) → 0x0064.
  - sign=1 → 0xFF9C.
  - zero_in=1 with any log_in and either sign → 0x0000, sat_out=0.
- Saturation: log_in=0x3000 → 0x7FFF, sat_out=1.
  - sign=1 → 0x8001.
  - After both are accepted, sat_cnt=2.
  - clr_cnt is asserted together with a third saturated transfer → sat_cnt=0.
- Backpressure: stream 8 operands back-to-back with out_ready held low for 5 cycles.
  - in_ready deasserts after S1..S3 fill.
  - Outputs stay stable while stalled.
  - All 8 results emerge in order with none lost or duplicated.
  - Random out_ready/in_valid for 1000 operands matches a reference model.
- Reset mid-stream: assert rst_n=0 with 3 operands in flight.
  - Outputs clear immediately (asynchronously).
  - After release, nothing is emitted until new input arrives.
  - sat_cnt=0.
